// File: rtl/ct_lsu_dcache_dirty_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ct_lsu_dcache_dirty_ctrl_pkg
// Purpose  : Shared types and size constants for the D-cache dirty-array
//            access controller and its invalidate-all walker.
// Contents : default geometry (selected by DCACHE_32K), walker state type,
//            counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package ct_lsu_dcache_dirty_ctrl_pkg;

`ifdef DCACHE_32K
  localparam int DEF_IDX_W = 8;
  localparam int DEF_DEPTH = 256;
`else
  localparam int DEF_IDX_W = 9;
  localparam int DEF_DEPTH = 512;
`endif
  localparam int DEF_DW     = 7;
  localparam int DEF_STARVE = 3;

  typedef enum logic [1:0] {
    WALK_IDLE = 2'd0,
    WALK_CLR  = 2'd1,
    WALK_DONE = 2'd2
  } walk_state_e;

  // Width needed to hold 0..maxval, never less than one bit.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ct_lsu_dcache_dirty_icc_walker.sv
`default_nettype none
// ============================================================================
// Module   : ct_lsu_dcache_dirty_icc_walker
// Purpose  : Invalidate-all walker. Steps through every dirty-array entry,
//            one per cycle, then raises a single-cycle done pulse.
// Ports    : clk, rst_n   - clock, async active-low reset
//            icc_req      - start request (sampled only in IDLE)
//            busy         - walker in CLR or DONE
//            done         - completion pulse (DONE state)
//            clr_idx      - index being cleared this cycle
//            clr_wr       - walker owns the array this cycle
// Revision : 1.0 - initial release
// ============================================================================
module ct_lsu_dcache_dirty_icc_walker
  import ct_lsu_dcache_dirty_ctrl_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icc_req,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] clr_idx,
  output logic             clr_wr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  walk_state_e      state, state_nxt;
  logic [IDX_W-1:0] clr_cnt, clr_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WALK_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    busy        = 1'b0;
    done        = 1'b0;
    clr_wr      = 1'b0;
    unique case (state)
      WALK_IDLE: begin
        if (icc_req) state_nxt = WALK_CLR;
      end
      WALK_CLR: begin
        busy        = 1'b1;
        clr_wr      = 1'b1;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) state_nxt = WALK_DONE;
      end
      WALK_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        clr_cnt_nxt = '0;
        state_nxt   = WALK_IDLE;
      end
      default: state_nxt = WALK_IDLE;
    endcase
  end

  assign clr_idx = clr_cnt;

endmodule
`default_nettype wire

// File: rtl/ct_lsu_dcache_dirty_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ct_lsu_dcache_dirty_ctrl
// Purpose  : Access controller for the single-port L1 D-cache dirty SRAM.
//            Arbitrates store/write-back writes, victim/snoop reads and the
//            invalidate-all walker; drives the array's active-low pins.
// Ports    : forever_cpuclk, cpurst_b         - clock, async active-low reset
//            wr_req/idx/din/mask, wr_gnt      - write port
//            rd_req/idx, rd_gnt               - read port
//            rd_data_vld, rd_data             - read return (1-cycle latency)
//            icc_req, icc_busy, icc_done      - invalidate-all control
//            dirty_*                          - SRAM pins and read data
// Revision : 1.0 - initial release
// ============================================================================
module ct_lsu_dcache_dirty_ctrl
  import ct_lsu_dcache_dirty_ctrl_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DW     = DEF_DW,
  parameter int STARVE = DEF_STARVE
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             wr_req,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [DW-1:0]    wr_din,
  input  logic [DW-1:0]    wr_mask,
  output logic             wr_gnt,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_gnt,
  output logic             rd_data_vld,
  output logic [DW-1:0]    rd_data,
  input  logic             icc_req,
  output logic             icc_busy,
  output logic             icc_done,
  output logic             dirty_gateclk_en,
  output logic             dirty_sel_b,
  output logic             dirty_gwen_b,
  output logic [DW-1:0]    dirty_wen_b,
  output logic [IDX_W-1:0] dirty_idx,
  output logic [DW-1:0]    dirty_din,
  input  logic [DW-1:0]    dirty_dout
);

  localparam int             SCW        = cnt_width(STARVE);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE);

  logic             walk_busy;
  logic             walk_done;
  logic             walk_wr;
  logic [IDX_W-1:0] walk_idx;
  logic [SCW-1:0]   starve_cnt;
  logic             rd_win;

  ct_lsu_dcache_dirty_icc_walker #(
    .IDX_W (IDX_W),
    .DEPTH (DEPTH)
  ) u_walker (
    .clk     (forever_cpuclk),
    .rst_n   (cpurst_b),
    .icc_req (icc_req),
    .busy    (walk_busy),
    .done    (walk_done),
    .clr_idx (walk_idx),
    .clr_wr  (walk_wr)
  );

  assign icc_busy = walk_busy;
  assign icc_done = walk_done;

  // Writes normally win; a read that has lost STARVE times in a row wins.
  // The walker's CLR cycles lock out both requesters.
  always_comb begin
    rd_win = rd_req & (~wr_req | (starve_cnt == STARVE_MAX));
    wr_gnt = ~walk_wr & wr_req & ~rd_win;
    rd_gnt = ~walk_wr & rd_win;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      starve_cnt <= '0;
    end else if (walk_wr) begin
      starve_cnt <= starve_cnt;
    end else if (!rd_req || rd_gnt) begin
      starve_cnt <= '0;
    end else if (wr_gnt && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    dirty_sel_b  = 1'b1;
    dirty_gwen_b = 1'b1;
    dirty_wen_b  = '1;
    dirty_idx    = '0;
    dirty_din    = '0;
    if (walk_wr) begin
      dirty_sel_b  = 1'b0;
      dirty_gwen_b = 1'b0;
      dirty_wen_b  = '0;
      dirty_idx    = walk_idx;
    end else if (wr_gnt) begin
      dirty_sel_b  = 1'b0;
      dirty_gwen_b = 1'b0;
      dirty_wen_b  = ~wr_mask;
      dirty_idx    = wr_idx;
      dirty_din    = wr_din;
    end else if (rd_gnt) begin
      dirty_sel_b  = 1'b0;
      dirty_idx    = rd_idx;
    end
  end

  assign dirty_gateclk_en = ~dirty_sel_b;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) rd_data_vld <= 1'b0;
    else           rd_data_vld <= rd_gnt;
  end

  assign rd_data = rd_data_vld ? dirty_dout : '0;

endmodule
`default_nettype wire
